// File: rtl/pc_stack_multi_if.sv
// Bus bundle for the program-counter stack: sequencing/op inputs from the core,
// PC, occupancy and flag outputs back to it.
interface pc_stack_multi_if #(
  parameter int WORD_W = 4,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4
);
  localparam int NWORDS = ADDR_W / WORD_W;
  localparam int LVL_W  = $clog2(DEPTH + 1);

  logic [2:0]        cycle;
  logic [1:0]        op;
  logic              op_strobe;
  logic [ADDR_W-1:0] target;
  logic [NWORDS-1:0] wr_sel;
  logic [WORD_W-1:0] wr_data;
  logic [ADDR_W-1:0] pc;
  logic [WORD_W-1:0] pc_word;
  logic              pc_enable;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic              underflow;

  modport master (
    output cycle, op, op_strobe, target, wr_sel, wr_data,
    input  pc, pc_word, pc_enable, level, overflow, underflow
  );

  modport slave (
    input  cycle, op, op_strobe, target, wr_sel, wr_data,
    output pc, pc_word, pc_enable, level, overflow, underflow
  );
endinterface

// File: rtl/pc_stack_multi.sv
// Program-counter stack for the nibble-serial core: word-serial PC increment with
// rippled carry, call/return/jump, per-word writes and overflow/underflow tracking.
module pc_stack_multi #(
  parameter int WORD_W   = 4,
  parameter int ADDR_W   = 12,
  parameter int DEPTH    = 4,
  parameter int OVF_MODE = 0
) (
  input  logic            clock,
  input  logic            reset,
  pc_stack_multi_if.slave bus
);
  localparam int NWORDS = ADDR_W / WORD_W;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int LVL_W  = $clog2(DEPTH + 1);

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_PUSH = 2'd1;
  localparam logic [1:0] OP_POP  = 2'd2;
  localparam logic [1:0] OP_JUMP = 2'd3;

  localparam logic [LVL_W-1:0] LVL_MAX    = LVL_W'(DEPTH - 1);
  localparam logic [2:0]       LAST_PHASE = 3'(NWORDS - 1);

  logic [ADDR_W-1:0] slot [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_up;
  logic [IDX_W-1:0]  idx_dn;
  logic              carry;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic              underflow;

  logic              addr_phase;
  logic              full;
  logic              empty;
  logic [ADDR_W-1:0] pc_top;
  logic [WORD_W-1:0] cur_word;
  logic              cin;
  logic [WORD_W:0]   inc_sum;
  logic [NWORDS-1:0] wr_low;

  assign addr_phase = bus.cycle < 3'(NWORDS);
  assign full       = level == LVL_MAX;
  assign empty      = level == '0;
  assign idx_up     = idx + IDX_W'(1);
  assign idx_dn     = idx - IDX_W'(1);
  assign pc_top     = slot[idx];
  // Isolate the lowest set select bit so only one word is ever written.
  assign wr_low     = bus.wr_sel & (~bus.wr_sel + NWORDS'(1));

  always_comb begin
    cur_word = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (bus.cycle == 3'(k)) cur_word = pc_top[k*WORD_W +: WORD_W];
    end
    cin     = (bus.cycle == 3'd0) ? 1'b1 : carry;
    inc_sum = {1'b0, cur_word} + {{WORD_W{1'b0}}, cin};
  end

  assign bus.pc        = pc_top;
  assign bus.pc_word   = addr_phase ? cur_word : '0;
  assign bus.pc_enable = addr_phase;
  assign bus.level     = level;
  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) slot[i] <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (addr_phase) begin
      for (int k = 0; k < NWORDS; k++) begin
        if (bus.cycle == 3'(k)) slot[idx][k*WORD_W +: WORD_W] <= inc_sum[WORD_W-1:0];
      end
      // The top word's carry-out is dropped so the PC wraps to zero.
      carry <= (bus.cycle == LAST_PHASE) ? 1'b0 : inc_sum[WORD_W];
    end else if (bus.op_strobe) begin
      case (bus.op)
        OP_NOP: ;
        OP_PUSH: begin
          if (full) overflow <= 1'b1;
          if (!full || OVF_MODE == 0) begin
            idx          <= idx_up;
            slot[idx_up] <= bus.target;
          end
          if (!full) level <= level + LVL_W'(1);
        end
        OP_POP: begin
          if (empty) underflow <= 1'b1;
          if (!empty || OVF_MODE == 0) idx <= idx_dn;
          if (!empty) level <= level - LVL_W'(1);
        end
        OP_JUMP: slot[idx] <= bus.target;
      endcase
    end else begin
      for (int k = 0; k < NWORDS; k++) begin
        if (wr_low[k]) slot[idx][k*WORD_W +: WORD_W] <= bus.wr_data;
      end
    end
  end
endmodule
